// File: rtl/proc_core_param.sv
// Parametrised multi-cycle processor core: register file, A/G temporaries and a
// four-state control FSM with a valid/ready instruction handshake and ALU flags.
module proc_core_param #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  localparam int RA    = $clog2(NREG)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [2*RA+2:0]   iin,
  input  logic [DATA_W-1:0] imm,
  input  logic              iin_valid,
  output logic              iin_ready,
  output logic [DATA_W-1:0] OutputProcessor,
  output logic              out_valid,
  output logic              done,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c
);

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_OUT = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_T1   = 2'd1;
  localparam logic [1:0] S_T2   = 2'd2;
  localparam logic [1:0] S_T3   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [2*RA+2:0]   ir_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] a_q, g_q;
  logic [DATA_W-1:0] out_q;
  logic              fz_q, fn_q, fc_q;
  logic [DATA_W-1:0] regs_q [NREG];

  logic [2:0]        op;
  logic [RA-1:0]     rx, ry;
  logic [DATA_W-1:0] rx_val, ry_val;
  logic [DATA_W:0]   alu_res;
  logic              is_alu;

  // Bit DATA_W of the result carries the carry-out (or no-borrow for SUB).
  function automatic logic [DATA_W:0] alu_f(input logic [2:0] f_op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    logic [DATA_W:0] r;
    r = '0;
    case (f_op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
      OP_AND:  r = {1'b0, a & b};
      OP_SLT:  r = {{DATA_W{1'b0}}, ($signed(a) < $signed(b))};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign op      = ir_q[2*RA+2 -: 3];
  assign rx      = ir_q[2*RA-1 -: RA];
  assign ry      = ir_q[RA-1:0];
  assign rx_val  = regs_q[rx];
  assign ry_val  = regs_q[ry];
  assign is_alu  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_SLT);
  assign alu_res = alu_f(op, a_q, ry_val);

  assign iin_ready       = (state_q == S_IDLE);
  assign done            = ((state_q == S_T1) && !is_alu) || (state_q == S_T3);
  assign out_valid       = (state_q == S_T1) && (op == OP_OUT);
  assign OutputProcessor = out_q;
  assign flag_z          = fz_q;
  assign flag_n          = fn_q;
  assign flag_c          = fc_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (iin_valid) state_d = S_T1;
      S_T1:    state_d = is_alu ? S_T2 : S_IDLE;
      S_T2:    state_d = S_T3;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      imm_q   <= '0;
      a_q     <= '0;
      g_q     <= '0;
      out_q   <= '0;
      fz_q    <= 1'b0;
      fn_q    <= 1'b0;
      fc_q    <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (iin_ready && iin_valid) begin
        ir_q  <= iin;
        imm_q <= imm;
      end
      case (state_q)
        S_T1: begin
          case (op)
            OP_MV:   regs_q[rx] <= ry_val;
            OP_MVI:  regs_q[rx] <= imm_q;
            OP_OUT:  out_q      <= rx_val;
            default: if (is_alu) a_q <= rx_val;
          endcase
        end
        S_T2: begin
          g_q  <= alu_res[DATA_W-1:0];
          fc_q <= alu_res[DATA_W];
          fz_q <= (alu_res[DATA_W-1:0] == '0);
          fn_q <= alu_res[DATA_W-1];
        end
        S_T3:    regs_q[rx] <= g_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_core_param.sv
// Directed bench for proc_core_param: a default 16-bit/8-register core plus an
// 8-bit/4-register instance for the parameter sweep.
module tb_proc_core_param;

  localparam logic [2:0] MV = 3'b000, MVI = 3'b001, ADD = 3'b010, SUB = 3'b011;
  localparam logic [2:0] OUTI = 3'b100, ANDI = 3'b101, SLT = 3'b110;

  logic        clock = 1'b0;
  logic        resetn;
  logic [8:0]  iin;
  logic [15:0] imm;
  logic        iin_valid, iin_ready, out_valid, done, flag_z, flag_n, flag_c;
  logic [15:0] OutputProcessor;

  logic [6:0]  iin8;
  logic [7:0]  imm8;
  logic        iin_valid8, iin_ready8, out_valid8, done8, flag_z8, flag_n8, flag_c8;
  logic [7:0]  OutputProcessor8;

  int   compared = 0;
  int   mismatched = 0;
  int   cyc;
  logic ov_seen;

  always #5 clock = ~clock;

  proc_core_param dut (
    .clock(clock), .resetn(resetn), .iin(iin), .imm(imm), .iin_valid(iin_valid),
    .iin_ready(iin_ready), .OutputProcessor(OutputProcessor), .out_valid(out_valid),
    .done(done), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c)
  );

  proc_core_param #(.DATA_W(8), .NREG(4)) dut8 (
    .clock(clock), .resetn(resetn), .iin(iin8), .imm(imm8), .iin_valid(iin_valid8),
    .iin_ready(iin_ready8), .OutputProcessor(OutputProcessor8), .out_valid(out_valid8),
    .done(done8), .flag_z(flag_z8), .flag_n(flag_n8), .flag_c(flag_c8)
  );

  // Issue one instruction from a negedge; returns at the negedge after done.
  task automatic exec(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry,
                      input logic [15:0] iv);
    int k;
    k = 0;
    while (!iin_ready && k < 10) begin @(negedge clock); k++; end
    iin = {op, rx, ry}; imm = iv; iin_valid = 1'b1;
    @(negedge clock);
    iin_valid = 1'b0; iin = '0; imm = '0;
    cyc = 0; ov_seen = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (out_valid) ov_seen = 1'b1;
      if (done) begin cyc = i; break; end
      @(negedge clock);
    end
    if (cyc == 0) begin
      compared++; mismatched++;
      $display("FAIL exec_timeout: op=%b no done within 8 cycles", op);
    end
    @(negedge clock);
  endtask

  task automatic exec8(input logic [2:0] op, input logic [1:0] rx, input logic [1:0] ry,
                       input logic [7:0] iv);
    iin8 = {op, rx, ry}; imm8 = iv; iin_valid8 = 1'b1;
    @(negedge clock);
    iin_valid8 = 1'b0;
    cyc = 0; ov_seen = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (out_valid8) ov_seen = 1'b1;
      if (done8) begin cyc = i; break; end
      @(negedge clock);
    end
    if (cyc == 0) begin
      compared++; mismatched++;
      $display("FAIL exec8_timeout: op=%b no done within 8 cycles", op);
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    resetn = 1'b0; iin = '0; imm = '0; iin_valid = 1'b0;
    iin8 = '0; imm8 = '0; iin_valid8 = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    compared++; if (iin_ready !== 1'b1) begin mismatched++; $display("FAIL rst_ready: got %b want 1", iin_ready); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL rst_done: got %b want 0", done); end
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    compared++; if (OutputProcessor !== 16'h0000) begin mismatched++; $display("FAIL rst_out: got %h want 0000", OutputProcessor); end
    compared++; if ({flag_z, flag_n, flag_c} !== 3'b000) begin mismatched++; $display("FAIL rst_flags: got %b want 000", {flag_z, flag_n, flag_c}); end
  endtask

  task automatic test_mvi_out();
    iin = {MVI, 3'd1, 3'd0}; imm = 16'h0005; iin_valid = 1'b1;
    @(negedge clock);
    iin_valid = 1'b0;
    compared++; if (iin_ready !== 1'b0) begin mismatched++; $display("FAIL mvi_busy: got %b want 0", iin_ready); end
    compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL mvi_done_t1: got %b want 1", done); end
    @(negedge clock);
    compared++; if (iin_ready !== 1'b1) begin mismatched++; $display("FAIL mvi_ready_back: got %b want 1", iin_ready); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL mvi_done_pulse: got %b want 0", done); end
    exec(OUTI, 3'd1, 3'd0, 16'h0);
    compared++; if (ov_seen !== 1'b1) begin mismatched++; $display("FAIL out_valid_pulse: got %b want 1", ov_seen); end
    compared++; if (cyc != 1) begin mismatched++; $display("FAIL out_latency: got %0d want 1", cyc); end
    compared++; if (OutputProcessor !== 16'h0005) begin mismatched++; $display("FAIL out_r1: got %h want 0005", OutputProcessor); end
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL out_valid_low: got %b want 0", out_valid); end
  endtask

  task automatic test_add();
    exec(MVI, 3'd2, 3'd0, 16'hFFFF);
    exec(MVI, 3'd3, 3'd0, 16'h0001);
    exec(ADD, 3'd2, 3'd3, 16'h0);
    compared++; if (cyc != 3) begin mismatched++; $display("FAIL add_latency: got %0d want 3", cyc); end
    compared++; if ({flag_z, flag_n, flag_c} !== 3'b101) begin mismatched++; $display("FAIL add_flags: got %b want 101", {flag_z, flag_n, flag_c}); end
    exec(OUTI, 3'd2, 3'd0, 16'h0);
    compared++; if (OutputProcessor !== 16'h0000) begin mismatched++; $display("FAIL add_result: got %h want 0000", OutputProcessor); end
  endtask

  task automatic test_sub_slt();
    exec(MVI, 3'd4, 3'd0, 16'h0003);
    exec(MVI, 3'd5, 3'd0, 16'h0007);
    exec(SUB, 3'd4, 3'd5, 16'h0);
    compared++; if ({flag_z, flag_n, flag_c} !== 3'b010) begin mismatched++; $display("FAIL sub_flags: got %b want 010", {flag_z, flag_n, flag_c}); end
    exec(OUTI, 3'd4, 3'd0, 16'h0);
    compared++; if (OutputProcessor !== 16'hFFFC) begin mismatched++; $display("FAIL sub_result: got %h want fffc", OutputProcessor); end
    exec(SLT, 3'd4, 3'd5, 16'h0);
    compared++; if ({flag_z, flag_n, flag_c} !== 3'b000) begin mismatched++; $display("FAIL slt_flags: got %b want 000", {flag_z, flag_n, flag_c}); end
    exec(OUTI, 3'd4, 3'd0, 16'h0);
    compared++; if (OutputProcessor !== 16'h0001) begin mismatched++; $display("FAIL slt_result: got %h want 0001", OutputProcessor); end
  endtask

  task automatic test_same_reg_and_mv();
    exec(SUB, 3'd3, 3'd3, 16'h0);
    compared++; if ({flag_z, flag_n, flag_c} !== 3'b101) begin mismatched++; $display("FAIL subself_flags: got %b want 101", {flag_z, flag_n, flag_c}); end
    exec(OUTI, 3'd3, 3'd0, 16'h0);
    compared++; if (OutputProcessor !== 16'h0000) begin mismatched++; $display("FAIL subself_result: got %h want 0000", OutputProcessor); end
    exec(MVI, 3'd6, 3'd0, 16'hF0F0);
    exec(MVI, 3'd7, 3'd0, 16'h3C3C);
    exec(ANDI, 3'd6, 3'd7, 16'h0);
    compared++; if ({flag_z, flag_n, flag_c} !== 3'b000) begin mismatched++; $display("FAIL and_flags: got %b want 000", {flag_z, flag_n, flag_c}); end
    exec(MVI, 3'd2, 3'd0, 16'h8000);
    exec(ADD, 3'd2, 3'd2, 16'h0);
    exec(MV, 3'd0, 3'd6, 16'h0);
    compared++; if ({flag_z, flag_n, flag_c} !== 3'b101) begin mismatched++; $display("FAIL mv_keeps_flags: got %b want 101", {flag_z, flag_n, flag_c}); end
    exec(OUTI, 3'd0, 3'd0, 16'h0);
    compared++; if (OutputProcessor !== 16'h3030) begin mismatched++; $display("FAIL and_mv_result: got %h want 3030", OutputProcessor); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] prog [3];
    int   idx, dones, last;
    logic acc;
    prog[0] = {MV, 3'd1, 3'd6};
    prog[1] = {MV, 3'd2, 3'd1};
    prog[2] = {MV, 3'd3, 3'd2};
    idx = 0; dones = 0; last = -1; acc = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (acc) idx++;
      if (done) begin dones++; last = c; end
      if (dones == 3) break;
      if (idx < 3) begin iin = prog[idx]; iin_valid = 1'b1; end
      else iin_valid = 1'b0;
      acc = iin_ready && iin_valid;
      @(negedge clock);
    end
    iin_valid = 1'b0;
    compared++; if (dones != 3) begin mismatched++; $display("FAIL b2b_dones: got %0d want 3", dones); end
    compared++; if (last + 1 != 6) begin mismatched++; $display("FAIL b2b_cycles: got %0d want 6", last + 1); end
    exec(OUTI, 3'd3, 3'd0, 16'h0);
    compared++; if (OutputProcessor !== 16'h3030) begin mismatched++; $display("FAIL b2b_chain: got %h want 3030", OutputProcessor); end
  endtask

  task automatic test_reset_mid();
    int dseen;
    exec(MVI, 3'd1, 3'd0, 16'h0005);
    iin = {ADD, 3'd1, 3'd1}; iin_valid = 1'b1;
    @(negedge clock);
    iin_valid = 1'b0;
    @(negedge clock);
    resetn = 1'b0;
    #1;
    compared++; if (iin_ready !== 1'b1) begin mismatched++; $display("FAIL midrst_ready: got %b want 1", iin_ready); end
    dseen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (done) dseen++;
      if (i == 0) resetn = 1'b1;
    end
    compared++; if (dseen != 0) begin mismatched++; $display("FAIL midrst_done: got %0d want 0", dseen); end
    compared++; if ({flag_z, flag_n, flag_c} !== 3'b000) begin mismatched++; $display("FAIL midrst_flags: got %b want 000", {flag_z, flag_n, flag_c}); end
    exec(OUTI, 3'd1, 3'd0, 16'h0);
    compared++; if (OutputProcessor !== 16'h0000) begin mismatched++; $display("FAIL midrst_r1: got %h want 0000", OutputProcessor); end
  endtask

  task automatic test_param();
    exec8(MVI, 2'd3, 2'd0, 8'h80);
    exec8(ADD, 2'd3, 2'd3, 8'h00);
    compared++; if (cyc != 3) begin mismatched++; $display("FAIL p8_latency: got %0d want 3", cyc); end
    compared++; if ({flag_z8, flag_n8, flag_c8} !== 3'b101) begin mismatched++; $display("FAIL p8_flags: got %b want 101", {flag_z8, flag_n8, flag_c8}); end
    exec8(OUTI, 2'd3, 2'd0, 8'h00);
    compared++; if (ov_seen !== 1'b1) begin mismatched++; $display("FAIL p8_out_valid: got %b want 1", ov_seen); end
    compared++; if (OutputProcessor8 !== 8'h00) begin mismatched++; $display("FAIL p8_result: got %h want 00", OutputProcessor8); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mvi_out();
    test_add();
    test_sub_slt();
    test_same_reg_and_mv();
    test_back_to_back();
    test_reset_mid();
    test_param();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
